brick_health_map: RTL and testbench

Per-brick health store for the brick field. It initialises every brick's health after reset and accumulates the field's total health. It accepts hit requests from the ball/collision logic, decrements the struck brick, and emits a one-cycle `game_write` pulse per successful hit to the downstream win checker. It also hands a redraw request for the changed brick to the drawing FSM.

---
 rtl/brick_health_map_if.sv | 29 ++
 rtl/brick_health_map.sv | 182 ++++++++++++++++++
 tb/tb_brick_health_map.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/brick_health_map_if.sv
// Hit-request and redraw handshakes for brick_health_map.
// master = requester / drawing side, slave = the health map itself.
interface brick_health_map_if #(
  parameter int ROW_W    = 3,
  parameter int COL_W    = 4,
  parameter int HEALTH_W = 2
);
  logic                hit_req;
  logic [ROW_W-1:0]    hit_row;
  logic [COL_W-1:0]    hit_col;
  logic                hit_ack;
  logic                hit_valid;

  logic                draw_req;
  logic [ROW_W-1:0]    draw_row;
  logic [COL_W-1:0]    draw_col;
  logic [HEALTH_W-1:0] draw_health;
  logic                draw_ack;

  modport master (
    output hit_req, hit_row, hit_col, draw_ack,
    input  hit_ack, hit_valid, draw_req, draw_row, draw_col, draw_health
  );

  modport slave (
    input  hit_req, hit_row, hit_col, draw_ack,
    output hit_ack, hit_valid, draw_req, draw_row, draw_col, draw_health
  );
endinterface

// File: rtl/brick_health_map.sv
// Per-brick health store: initialises the field, services hits, requests redraws.
// Optional macro BRICK_PATTERN_EN: row r starts at max(1, INIT_HEALTH-r) instead of INIT_HEALTH.
module brick_health_map #(
  parameter int ROWS        = 4,
  parameter int COLS        = 8,
  parameter int ROW_W       = 3,
  parameter int COL_W       = 4,
  parameter int HEALTH_W    = 2,
  parameter int INIT_HEALTH = 3
) (
  input  logic                clk,
  input  logic                resetn,
  brick_health_map_if.slave   bus,
  output logic                game_write,
  input  logic [ROW_W-1:0]    query_row,
  input  logic [COL_W-1:0]    query_col,
  output logic [HEALTH_W-1:0] query_health,
  output logic [9:0]          total_health,
  output logic                ready
);

  localparam int N      = ROWS * COLS;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_HIT, ST_DRAW} state_t;

  state_t state, state_nxt;

  logic [HEALTH_W-1:0] bricks [N];
  logic [CNT_W-1:0]    init_cnt;
  logic [HEALTH_W-1:0] init_val;
  logic [ROW_W-1:0]    lat_row;
  logic [COL_W-1:0]    lat_col;

  function automatic logic in_range(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return (int'(r) < ROWS) && (int'(c) < COLS);
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  logic                hit_in_range, hit_ok;
  logic [ADDR_W-1:0]   hit_addr;
  logic [HEALTH_W-1:0] hit_cur;
  logic                q_in_range;
  logic [ADDR_W-1:0]   q_addr;

  assign hit_in_range = in_range(lat_row, lat_col);
  assign hit_addr     = to_addr(lat_row, lat_col);
  assign hit_cur      = bricks[hit_addr];
  assign hit_ok       = hit_in_range && (hit_cur != '0);
  assign q_in_range   = in_range(query_row, query_col);
  assign q_addr       = to_addr(query_row, query_col);

`ifdef BRICK_PATTERN_EN
  // Row/column of the brick being initialised; only the row shapes the pattern.
  logic [ROW_W-1:0] init_row;
  logic [COL_W-1:0] init_col;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_row <= '0;
      init_col <= '0;
    end else if (state == ST_INIT && int'(init_cnt) < N) begin
      if (int'(init_col) == COLS - 1) begin
        init_col <= '0;
        init_row <= init_row + ROW_W'(1);
      end else begin
        init_col <= init_col + COL_W'(1);
      end
    end
  end

  assign init_val = (int'(init_row) >= INIT_HEALTH - 1) ? HEALTH_W'(1)
                                                        : HEALTH_W'(INIT_HEALTH - int'(init_row));
`else
  assign init_val = HEALTH_W'(INIT_HEALTH);
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_INIT;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (int'(init_cnt) == N) state_nxt = ST_IDLE;
      ST_IDLE: if (bus.hit_req) state_nxt = ST_HIT;
      ST_HIT:  state_nxt = hit_ok ? ST_DRAW : ST_IDLE;
      ST_DRAW: if (bus.draw_req && bus.draw_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output / datapath control
  logic                mem_we, init_step, latch_en, hit_done, draw_load;
  logic [ADDR_W-1:0]   mem_addr;
  logic [HEALTH_W-1:0] mem_wdata;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    mem_we    = 1'b0;
    mem_addr  = hit_addr;
    mem_wdata = hit_cur - HEALTH_W'(1);
    init_step = 1'b0;
    latch_en  = 1'b0;
    hit_done  = 1'b0;
    draw_load = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (int'(init_cnt) < N) begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(init_cnt);
          mem_wdata = init_val;
          init_step = 1'b1;
        end
      end
      ST_IDLE: latch_en = bus.hit_req;
      ST_HIT: begin
        hit_done = 1'b1;
        if (hit_ok) begin
          mem_we    = 1'b1;
          draw_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the brick array is reset explicitly so a mid-game reset restores a clean field.
      for (int i = 0; i < N; i++) bricks[i] <= '0;
      init_cnt        <= '0;
      total_health    <= '0;
      ready           <= 1'b0;
      lat_row         <= '0;
      lat_col         <= '0;
      bus.hit_ack     <= 1'b0;
      bus.hit_valid   <= 1'b0;
      game_write      <= 1'b0;
      bus.draw_req    <= 1'b0;
      bus.draw_row    <= '0;
      bus.draw_col    <= '0;
      bus.draw_health <= '0;
      query_health    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (mem_we) bricks[mem_addr] <= mem_wdata;
      if (init_step) begin
        init_cnt     <= init_cnt + CNT_W'(1);
        total_health <= total_health + 10'(init_val);
      end
      if (state == ST_INIT && int'(init_cnt) == N) ready <= 1'b1;
      if (latch_en) begin
        lat_row <= bus.hit_row;
        lat_col <= bus.hit_col;
      end
      bus.hit_ack   <= hit_done;
      bus.hit_valid <= hit_done && hit_ok;
      game_write    <= hit_done && hit_ok;
      // Rises one cycle into DRAW, drops the cycle after draw_ack is seen with it high.
      bus.draw_req  <= (state == ST_DRAW) && !(bus.draw_req && bus.draw_ack);
      if (draw_load) begin
        bus.draw_row    <= lat_row;
        bus.draw_col    <= lat_col;
        bus.draw_health <= mem_wdata;
      end
      // A hit write landing this edge is forwarded so the query never sees stale health.
      if (!q_in_range)                        query_health <= '0;
      else if (draw_load && hit_addr == q_addr) query_health <= mem_wdata;
      else                                    query_health <= bricks[q_addr];
    end
  end

endmodule

// File: tb/tb_brick_health_map.sv
// Self-checking bench for brick_health_map: directed steps plus random hits
// against a per-brick health array model.
module tb_brick_health_map;

  localparam int ROWS        = 4;
  localparam int COLS        = 8;
  localparam int ROW_W       = 3;
  localparam int COL_W       = 4;
  localparam int HEALTH_W    = 2;
  localparam int INIT_HEALTH = 3;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                game_write;
  logic [ROW_W-1:0]    query_row = '0;
  logic [COL_W-1:0]    query_col = '0;
  logic [HEALTH_W-1:0] query_health;
  logic [9:0]          total_health;
  logic                ready;

  brick_health_map_if #(.ROW_W(ROW_W), .COL_W(COL_W), .HEALTH_W(HEALTH_W)) bus ();

  brick_health_map #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .HEALTH_W(HEALTH_W), .INIT_HEALTH(INIT_HEALTH)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .game_write(game_write),
    .query_row(query_row), .query_col(query_col), .query_health(query_health),
    .total_health(total_health), .ready(ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model [ROWS][COLS];

  function automatic int init_h(input int r);
`ifdef BRICK_PATTERN_EN
    return (INIT_HEALTH - r < 1) ? 1 : INIT_HEALTH - r;
`else
    return INIT_HEALTH;
`endif
  endfunction

  function automatic int model_total();
    int s = 0;
    for (int r = 0; r < ROWS; r++) s += COLS * init_h(r);
    return s;
  endfunction

  function automatic int model_query(input int r, input int c);
    if (r < ROWS && c < COLS) return model[r][c];
    return 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = init_h(r);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.hit_ack, bus.hit_valid, game_write, bus.draw_req, ready,
                bus.draw_row, bus.draw_col, bus.draw_health, query_health, total_health}, 0);
  endtask

  // Releases reset and checks that ready rises exactly ROWS*COLS+1 edges later.
  task automatic release_and_init();
    @(negedge clk);
    resetn = 1'b1;
    repeat (ROWS * COLS) @(negedge clk);
    check("ready_before_done", ready, 0);
    @(negedge clk);
    check("ready_rise", ready, 1);
    check("total_health", total_health, model_total());
  endtask

  task automatic query(input int r, input int c, input string tag);
    query_row = ROW_W'(r);
    query_col = COL_W'(c);
    @(negedge clk);
    check(tag, query_health, model_query(r, c));
  endtask

  // One hit transaction; delay = cycles draw_ack is withheld once draw_req is up.
  task automatic do_hit(input int r, input int c, input int delay);
    int  lat, cnt, exp_h;
    bit  valid;
    valid = model_query(r, c) > 0;
    bus.hit_req  = 1'b1;
    bus.hit_row  = ROW_W'(r);
    bus.hit_col  = COL_W'(c);
    bus.draw_ack = (delay == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.hit_ack && lat < 50);
    bus.hit_req = 1'b0;
    check("hit_ack_latency", lat, 2);
    check("hit_valid", bus.hit_valid, valid);
    check("game_write", game_write, valid);
    if (valid) begin
      model[r][c]--;
      exp_h = model[r][c];
      @(negedge clk);
      check("ack_one_pulse", {bus.hit_ack, game_write}, 0);
      check("draw_req_rise", bus.draw_req, 1);
      cnt = 0;
      while (bus.draw_req && cnt < 100) begin
        check("draw_coord", {bus.draw_row, bus.draw_col}, {ROW_W'(r), COL_W'(c)});
        check("draw_health", bus.draw_health, exp_h);
        cnt++;
        if (cnt >= delay) bus.draw_ack = 1'b1;
        @(negedge clk);
      end
      check("draw_len", cnt, (delay < 1) ? 1 : delay);
      bus.draw_ack = 1'b0;
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("no_draw_on_miss", {bus.draw_req, bus.hit_ack, game_write}, 0);
      end
    end
    query(r, c, "query_after_hit");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    bus.hit_req  = 1'b0;
    bus.hit_row  = '0;
    bus.hit_col  = '0;
    bus.draw_ack = 1'b0;
    model_reset();

    // Reset values and INIT timing
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    release_and_init();

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) query(r, c, "query_init");
    query(5, 9, "query_oor");
    query(ROWS, 0, "query_oor_row");
    query(0, COLS, "query_oor_col");

    // Repeated hits down to zero, then a hit on an empty brick
    for (int k = 0; k < 4; k++) do_hit(2, 4, 0);
    check("health_floor", model_query(2, 4), 0);
    query(2, 4, "query_empty_brick");
    do_hit(5, 9, 0);
    do_hit(0, COLS, 2);

    // Random hits concentrated on a few bricks so several reach zero
    for (int k = 0; k < 40; k++) begin
      int r, c, d;
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 7))  : int'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 2));
      d = int'($urandom_range(0, 3));
      do_hit(r, c, d);
    end

    // Withhold draw_ack, then reset in the middle of DRAW
    bus.hit_req  = 1'b1;
    bus.hit_row  = ROW_W'(1);
    bus.hit_col  = COL_W'(6);
    bus.draw_ack = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.hit_ack && lat < 50);
    bus.hit_req = 1'b0;
    check("stall_hit_valid", bus.hit_valid, model_query(1, 6) > 0);
    if (model_query(1, 6) > 0) model[1][6]--;
    @(negedge clk);
    repeat (10) begin
      check("stall_draw_req", bus.draw_req, 1);
      check("stall_draw_stable", {bus.draw_row, bus.draw_col, bus.draw_health},
            {ROW_W'(1), COL_W'(6), HEALTH_W'(model[1][6])});
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    check_outputs_zero("abort_outputs");
    model_reset();

    // hit_req held through INIT is serviced only after ready
    bus.hit_req = 1'b1;
    bus.hit_row = ROW_W'(3);
    bus.hit_col = COL_W'(7);
    @(negedge clk);
    resetn = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.hit_ack && lat < 200);
    bus.hit_req = 1'b0;
    check("init_hit_latency", lat, ROWS * COLS + 3);
    check("init_hit_ready", ready, 1);
    check("init_hit_valid", bus.hit_valid, 1);
    check("rerun_total", total_health, model_total());
    model[3][7]--;
    bus.draw_ack = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.draw_req && cnt < 50);
    bus.draw_ack = 1'b0;
    check("init_hit_draw_len", cnt, 2);
    query(1, 6, "restored_brick");
    query(3, 7, "post_reset_hit");
    query(2, 4, "restored_emptied");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
